// File: rtl/box_physics_pkg.sv
`default_nettype none
// ============================================================================
// box_physics_pkg : state encoding, default physics constants and helpers
//                   shared by the flappy-box physics register.
// Revision 1.0
// ============================================================================
package box_physics_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2,
    ST_CRASHED = 2'd3
  } state_e;

  localparam int DEF_Y_WIDTH       = 7;
  localparam int DEF_V_WIDTH       = 5;
  localparam int DEF_Y_START       = 60;
  localparam int DEF_Y_MIN         = 0;
  localparam int DEF_Y_MAX         = 119;
  localparam int DEF_GRAVITY       = 1;
  localparam int DEF_FLAP_VELOCITY = -6;
  localparam int DEF_V_MAX         = 8;

  function automatic int sat_clamp(input int x, input int lo, input int hi);
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/box_kinematics.sv
`default_nettype none
// ============================================================================
// box_kinematics : combinational one-tick position/velocity update with
//                  ceiling clamp, ground detection and terminal velocity.
// Revision 1.0
// ============================================================================
module box_kinematics
  import box_physics_pkg::*;
#(
  parameter int Y_WIDTH       = DEF_Y_WIDTH,
  parameter int V_WIDTH       = DEF_V_WIDTH,
  parameter int Y_MIN         = DEF_Y_MIN,
  parameter int Y_MAX         = DEF_Y_MAX,
  parameter int GRAVITY       = DEF_GRAVITY,
  parameter int FLAP_VELOCITY = DEF_FLAP_VELOCITY,
  parameter int V_MAX         = DEF_V_MAX
) (
  input  logic                      y_i_unused_guard_n,
  input  logic [Y_WIDTH-1:0]        y_i,
  input  logic signed [V_WIDTH-1:0] v_i,
  input  logic                      flap_i,
  output logic [Y_WIDTH-1:0]        y_next_o,
  output logic signed [V_WIDTH-1:0] v_next_o,
  output logic                      hit_ceiling_o,
  output logic                      hit_ground_o
);

  localparam int SW  = Y_WIDTH + 2;
  localparam int VW1 = V_WIDTH + 1;
  localparam logic signed [SW-1:0]  C_Y_MIN   = SW'(Y_MIN);
  localparam logic signed [SW-1:0]  C_Y_MAX   = SW'(Y_MAX);
  localparam logic signed [VW1-1:0] C_GRAVITY = VW1'(GRAVITY);
  localparam int                    C_V_LO    = -(2 ** (V_WIDTH - 1));

  logic signed [V_WIDTH-1:0] w_v_eff;
  logic signed [SW-1:0]      w_sum;
  logic signed [VW1-1:0]     w_v_grav;

  always_comb begin
    w_v_eff  = flap_i ? V_WIDTH'(FLAP_VELOCITY) : v_i;
    // Two guard bits keep the sum from wrapping in either direction.
    w_sum    = $signed({2'b00, y_i}) + $signed({{(SW-V_WIDTH){w_v_eff[V_WIDTH-1]}}, w_v_eff});
    w_v_grav = $signed({w_v_eff[V_WIDTH-1], w_v_eff}) + C_GRAVITY;

    hit_ceiling_o = (w_sum <= C_Y_MIN) && y_i_unused_guard_n;
    hit_ground_o  = !hit_ceiling_o && (w_sum >= C_Y_MAX);

    if (hit_ceiling_o) begin
      y_next_o = Y_WIDTH'(Y_MIN);
      v_next_o = '0;
    end else if (hit_ground_o) begin
      y_next_o = Y_WIDTH'(Y_MAX);
      v_next_o = '0;
    end else begin
      y_next_o = w_sum[Y_WIDTH-1:0];
      v_next_o = V_WIDTH'(sat_clamp(int'(w_v_grav), C_V_LO, V_MAX));
    end
  end

endmodule
`default_nettype wire

// File: rtl/box_physics_register.sv
`default_nettype none
// ============================================================================
// box_physics_register : flappy-box vertical physics with IDLE/RISING/
//                        FALLING/CRASHED FSM and a between-tick tap latch.
// Revision 1.0
// ============================================================================
module box_physics_register
  import box_physics_pkg::*;
#(
  parameter int Y_WIDTH       = DEF_Y_WIDTH,
  parameter int V_WIDTH       = DEF_V_WIDTH,
  parameter int Y_START       = DEF_Y_START,
  parameter int Y_MIN         = DEF_Y_MIN,
  parameter int Y_MAX         = DEF_Y_MAX,
  parameter int GRAVITY       = DEF_GRAVITY,
  parameter int FLAP_VELOCITY = DEF_FLAP_VELOCITY,
  parameter int V_MAX         = DEF_V_MAX
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      game_tick,
  input  logic                      tap,
  output logic [Y_WIDTH-1:0]        y_coordinate,
  output logic signed [V_WIDTH-1:0] velocity,
  output logic                      flying,
  output logic                      crashed,
  output logic                      crash_pulse,
  output logic [1:0]                state
);

  state_e                    state_q;
  logic [Y_WIDTH-1:0]        y_q;
  logic signed [V_WIDTH-1:0] v_q;
  logic                      flap_pending_q;
  logic                      flying_q;
  logic                      crashed_q;
  logic                      crash_pulse_q;

  logic [Y_WIDTH-1:0]        y_d;
  logic signed [V_WIDTH-1:0] v_d;
  logic                      hit_ceiling;
  logic                      hit_ground;
  logic                      flap;

  assign flap = flap_pending_q | tap;

  box_kinematics #(
    .Y_WIDTH       (Y_WIDTH),
    .V_WIDTH       (V_WIDTH),
    .Y_MIN         (Y_MIN),
    .Y_MAX         (Y_MAX),
    .GRAVITY       (GRAVITY),
    .FLAP_VELOCITY (FLAP_VELOCITY),
    .V_MAX         (V_MAX)
  ) u_kinematics (
    .y_i_unused_guard_n (1'b1),
    .y_i                (y_q),
    .v_i                (v_q),
    .flap_i             (flap),
    .y_next_o           (y_d),
    .v_next_o           (v_d),
    .hit_ceiling_o      (hit_ceiling),
    .hit_ground_o       (hit_ground)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      y_q            <= Y_WIDTH'(Y_START);
      v_q            <= '0;
      flap_pending_q <= 1'b0;
      flying_q       <= 1'b0;
      crashed_q      <= 1'b0;
      crash_pulse_q  <= 1'b0;
    end else begin
      crash_pulse_q <= 1'b0;
      if (game_tick) begin
        flap_pending_q <= 1'b0;
        if (state_q == ST_CRASHED) begin
          // The restart tap only re-arms the game; it does not flap.
          if (flap) begin
            state_q   <= ST_IDLE;
            y_q       <= Y_WIDTH'(Y_START);
            v_q       <= '0;
            crashed_q <= 1'b0;
            flying_q  <= 1'b0;
          end
        end else if (state_q != ST_IDLE || flap) begin
          y_q <= y_d;
          v_q <= v_d;
          if (hit_ground) begin
            state_q       <= ST_CRASHED;
            crashed_q     <= 1'b1;
            flying_q      <= 1'b0;
            crash_pulse_q <= 1'b1;
          end else if (v_d[V_WIDTH-1]) begin
            state_q  <= ST_RISING;
            flying_q <= 1'b1;
          end else begin
            state_q  <= ST_FALLING;
            flying_q <= 1'b0;
          end
        end
      end else if (tap) begin
        flap_pending_q <= 1'b1;
      end
    end
  end

  assign y_coordinate = y_q;
  assign velocity     = v_q;
  assign flying       = flying_q;
  assign crashed      = crashed_q;
  assign crash_pulse  = crash_pulse_q;
  assign state        = state_q;

  logic unused_ok;
  assign unused_ok = hit_ceiling;

endmodule
`default_nettype wire

// File: tb/tb_box_physics_register.sv
`default_nettype none
// ============================================================================
// tb_box_physics_register : directed and randomized checks of the box
//                           physics register against a behavioural model.
// Revision 1.0
// ============================================================================
module tb_box_physics_register;

  logic              clk;
  logic              rst;
  logic              game_tick;
  logic              tap;
  logic [6:0]        y_coordinate;
  logic signed [4:0] velocity;
  logic              flying;
  logic              crashed;
  logic              crash_pulse;
  logic [1:0]        state;

  int n_checks;
  int n_pass;

  // behavioural model state
  int m_y;
  int m_v;
  int m_st;
  bit m_pend;
  bit m_pulse;

  box_physics_register dut (
    .CLOCK_50     (clk),
    .reset        (rst),
    .game_tick    (game_tick),
    .tap          (tap),
    .y_coordinate (y_coordinate),
    .velocity     (velocity),
    .flying       (flying),
    .crashed      (crashed),
    .crash_pulse  (crash_pulse),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_y = 60; m_v = 0; m_st = 0; m_pend = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit tk, input bit tp);
    int ve;
    int s;
    bit f;
    m_pulse = 1'b0;
    if (tk) begin
      f = m_pend | tp;
      m_pend = 1'b0;
      if (m_st == 3) begin
        if (f) begin m_st = 0; m_y = 60; m_v = 0; end
      end else if (m_st != 0 || f) begin
        ve = f ? -6 : m_v;
        s  = m_y + ve;
        if (s <= 0) begin
          m_y = 0; m_v = 0; m_st = 2;
        end else if (s >= 119) begin
          m_y = 119; m_v = 0; m_st = 3; m_pulse = 1'b1;
        end else begin
          m_y = s;
          m_v = (ve + 1 > 8) ? 8 : ve + 1;
          m_st = (m_v < 0) ? 1 : 2;
        end
      end
    end else if (tp) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".y"}, int'(y_coordinate), m_y);
    check({where, ".v"}, int'(velocity), m_v);
    check({where, ".state"}, int'(state), m_st);
    check({where, ".flying"}, int'(flying), int'(m_st == 1));
    check({where, ".crashed"}, int'(crashed), int'(m_st == 3));
    check({where, ".pulse"}, int'(crash_pulse), int'(m_pulse));
  endtask

  // Called just after a rising edge; drives one cycle and checks its result.
  task automatic cycle(input bit tk, input bit tp, input string where);
    game_tick = tk;
    tap       = tp;
    @(posedge clk);
    model_step(tk, tp);
    #1;
    game_tick = 1'b0;
    tap       = 1'b0;
    check_all(where);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int exp_y[6] = '{54, 49, 45, 42, 40, 39};
  int exp_v[6] = '{-5, -4, -3, -2, -1, 0};
  int pulses;

  initial begin
    n_checks = 0; n_pass = 0; pulses = 0;
    rst = 1'b0; game_tick = 1'b0; tap = 1'b0;
    model_reset();
    #2;
    do_reset();
    check_all("reset");

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "idle_tick");

    cycle(1'b0, 1'b1, "idle_tap");
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, "rise");
      check("rise_seq.y", int'(y_coordinate), exp_y[i]);
      check("rise_seq.v", int'(velocity), exp_v[i]);
      check("rise_seq.flying", int'(flying), int'(i < 5));
    end
    check("rise_end.state", int'(state), 2);

    for (int i = 0; i < 30 && m_st != 3; i++) begin
      cycle(1'b1, 1'b0, "fall");
      if (crash_pulse) pulses++;
    end
    check("crash.y", int'(y_coordinate), 119);
    check("crash.crashed", int'(crashed), 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, "crashed_hold");
      if (crash_pulse) pulses++;
    end
    check("crash.pulse_count", pulses, 1);

    cycle(1'b0, 1'b1, "restart_tap");
    cycle(1'b1, 1'b0, "restart_tick");
    check("restart.y", int'(y_coordinate), 60);
    cycle(1'b1, 1'b1, "tap_and_tick");
    check("tap_and_tick.v", int'(velocity), -5);

    // climb to row 3 while rising, then flap into the ceiling
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, "climb");
    cycle(1'b1, 1'b0, "coast");
    cycle(1'b1, 1'b0, "coast");
    check("pre_ceiling.y", int'(y_coordinate), 3);
    cycle(1'b1, 1'b1, "ceiling");
    check("ceiling.y", int'(y_coordinate), 0);
    check("ceiling.state", int'(state), 2);

    // asynchronous reset between edges, with a tap pending
    cycle(1'b0, 1'b1, "pend_before_reset");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("after_reset");
    cycle(1'b1, 1'b0, "pend_cleared");

    cycle(1'b0, 1'b1, "double_tap1");
    cycle(1'b0, 1'b1, "double_tap2");
    cycle(1'b1, 1'b0, "double_tick1");
    cycle(1'b1, 1'b0, "double_tick2");
    check("double_tap.y", int'(y_coordinate), 49);

    for (int ep = 0; ep < 12; ep++) begin
      int tap_pct;
      tap_pct = int'($urandom_range(3, 25));
      do_reset();
      check_all("rand_reset");
      for (int c = 0; c < 250; c++) begin
        bit tk;
        bit tp;
        tk = ($urandom_range(0, 99) < 35);
        tp = (int'($urandom_range(0, 99)) < tap_pct);
        cycle(tk, tp, "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
